gray2bin_serial: RTL
====================

Name: gray2bin_serial

Overview:
- Sequential Gray-to-binary decoder; the inverse of the existing binary-to-Gray converter.
- Accepts one Gray word over a valid/ready handshake and resolves it MSB-first, one bit per clock (BIN[i] = BIN[i+1] ^ GRAY[i]).
- Presents the binary word over a second valid/ready handshake.
- Flags any accepted word that differs from the previously accepted word by more than one bit, i.e. an illegal Gray step. Used for position/pointer counters fed by Gray-coded sources.

Parameters:
- NUM_PIN, 3, index of the MSB; word width is NUM_PIN+1 bits. Legal values are 1 or more.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- GRAY_IN  input  NUM_PIN+1  Gray word, sampled on an input handshake.
- IN_VALID  input  1  GRAY_IN is valid.
- IN_READY  output  1  block can accept a word.
- BIN_OUT  output  NUM_PIN+1  decoded binary word.
- OUT_VALID  output  1  BIN_OUT and STEP_ERR are valid.
- OUT_READY  input  1  downstream accepts the result.
- STEP_ERR  output  1  accepted word was an illegal Gray step from the previous word.

Behaviour:
- Interface: one clock (CLK); reset RST_N is asynchronous and active-low.
- Reset values: state=IDLE, IN_READY=1, OUT_VALID=0, BIN_OUT=0, STEP_ERR=0, internal work regs=0, prev-word-valid flag=0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - IN_READY=1.
  - Input handshake = IN_VALID & IN_READY at a rising edge.
  - On the handshake: latch GRAY_IN into the shadow register, idx=NUM_PIN, acc=0, go to SHIFT.
- SHIFT:
  - IN_READY=0.
  - Each cycle: acc = acc ^ shadow[idx]; work[idx] = acc; idx decrements.
  - When idx==0 has been processed: load BIN_OUT from the final work value, set OUT_VALID=1, go to DONE.
  - SHIFT lasts exactly NUM_PIN+1 cycles, so OUT_VALID rises NUM_PIN+1 clocks after the accepting edge (4 clocks for the default).
- DONE:
  - OUT_VALID=1; BIN_OUT and STEP_ERR are held stable until the output handshake (OUT_VALID & OUT_READY).
  - On the handshake: OUT_VALID=0, STEP_ERR=0, go to IDLE. IN_READY returns to 1 on that same edge.
  - There is no input acceptance in DONE, so the minimum period between accepts is NUM_PIN+3 cycles.
- BIN_OUT changes only on DONE entry. Between results it keeps the last decoded value.
- Step check:
  - Evaluated at the input handshake: d = GRAY_IN ^ prev_word.
  - STEP_ERR is set when the prev-word-valid flag is 1 and popcount(d) > 1.
  - d==0 (repeated word) and popcount(d)==1 are legal.
  - At the handshake, prev_word = GRAY_IN and prev-word-valid = 1.
  - The first word after reset never flags.
  - STEP_ERR is launched at the accepting edge but is only meaningful while OUT_VALID=1.
- IN_VALID asserted while IN_READY=0 is ignored; the block never samples GRAY_IN outside IDLE.
- IN_VALID and the output handshake in the same cycle: the output handshake is taken in DONE. The input word waits until IDLE.
- RST_N asserted mid-SHIFT or mid-DONE: immediately return to reset values. The partial result is discarded and the prev-word-valid flag is cleared.
- OUT_READY held high continuously: DONE lasts exactly one cycle.

Decomposition:
- Shared package gray_pkg holds:
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - a width-helper function for the idx counter (clog2 of NUM_PIN+1).
- Natural sub-module: gray_step_check, a combinational popcount-greater-than-1 test on two NUM_PIN+1 words, reusable by other Gray-pointer consumers.
- The FSM and datapath stay in gray2bin_serial.

Test Plan:
- Reset, then GRAY_IN=4'b1011 with IN_VALID pulsed and OUT_READY=1 -> OUT_VALID rises 4 clocks after accept, BIN_OUT=4'b1101, STEP_ERR=0.
- Feed the full Gray sequence for 0..15 (0000,0001,0011,...,1000) back-to-back -> BIN_OUT=0..15 in order, STEP_ERR always 0, accepts spaced 6 cycles apart.
- Accept 4'b0000, then 4'b0011 -> second result BIN_OUT=4'b0010 with STEP_ERR=1. Then 4'b0011 again -> BIN_OUT=4'b0010, STEP_ERR=0.
- OUT_READY=0 for 10 cycles after a result (GRAY_IN=4'b1000) -> BIN_OUT=4'b1111 and OUT_VALID held, IN_READY=0, a new IN_VALID is ignored. Raising OUT_READY -> IDLE next edge.
- Pulse RST_N low 2 cycles into SHIFT -> all outputs return to reset values at once. The next word, e.g. 4'b1111 after 4'b0000 earlier, gives STEP_ERR=0 because history was cleared.
- NUM_PIN=7, GRAY_IN=8'hFF -> BIN_OUT=8'hAA after 8 SHIFT cycles.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for Gray-code consumers: FSM state encoding and
// sizing helpers.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold a bit index in the range 0..num_pin.
    function automatic int unsigned idx_width(input int unsigned num_pin);
        return (num_pin < 1) ? 1 : $clog2(num_pin + 1);
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Flags when two Gray words differ in more than one bit position,
// i.e. the second word is not a legal single Gray step from the first.
module gray_step_check #(
    parameter int unsigned NUM_PIN = 3
) (
    input  logic [NUM_PIN:0] word_a,
    input  logic [NUM_PIN:0] word_b,
    output logic             multi_bit
);

    logic [NUM_PIN:0] diff;

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        diff      = word_a ^ word_b;
        multi_bit = |(diff & (diff - {{NUM_PIN{1'b0}}, 1'b1}));
    end

endmodule

// File: rtl/gray2bin_serial.sv
// Serial Gray-to-binary decoder: accepts a Gray word, resolves it MSB-first one
// bit per clock and presents the binary word, flagging illegal Gray steps.
module gray2bin_serial
    import gray_pkg::*;
#(
    parameter int unsigned NUM_PIN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_PIN:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NUM_PIN:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             step_err
);

    localparam int unsigned   IW      = idx_width(NUM_PIN);
    localparam logic [IW-1:0] IDX_MSB = IW'(NUM_PIN);

    state_t           state_q, state_d;
    logic [NUM_PIN:0] shadow_q, shadow_d;
    logic [NUM_PIN:0] work_q, work_d;
    logic [NUM_PIN:0] bin_q, bin_d;
    logic [NUM_PIN:0] prev_q, prev_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             acc_q, acc_d;
    logic             prev_valid_q, prev_valid_d;
    logic             step_err_q, step_err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             multi_bit;

    gray_step_check #(
        .NUM_PIN (NUM_PIN)
    ) u_step_check (
        .word_a    (gray_in),
        .word_b    (prev_q),
        .multi_bit (multi_bit)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        work_d       = work_q;
        bin_d        = bin_q;
        prev_d       = prev_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        prev_valid_d = prev_valid_q;
        step_err_d   = step_err_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shadow_d     = gray_in;
                    work_d       = '0;
                    idx_d        = IDX_MSB;
                    acc_d        = 1'b0;
                    step_err_d   = prev_valid_q & multi_bit;
                    prev_d       = gray_in;
                    prev_valid_d = 1'b1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                acc_d         = acc_q ^ shadow_q[idx_q];
                work_d[idx_q] = acc_d;
                if (idx_q == '0) begin
                    bin_d   = work_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    step_err_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags get their own flops so outputs never decode from state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            work_q       <= '0;
            bin_q        <= '0;
            prev_q       <= '0;
            idx_q        <= '0;
            acc_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            step_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            work_q       <= work_d;
            bin_q        <= bin_d;
            prev_q       <= prev_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            prev_valid_q <= prev_valid_d;
            step_err_q   <= step_err_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign step_err  = step_err_q;

endmodule
